// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one step per cycle, sign correction on the final edge.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t state_q, state_d;
    logic   load, step, fin;

    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q, rem_neg_q, spec_q;

    logic              a_sgn, b_sgn, a_neg, b_neg, special;
    logic [XLEN-1:0]   a_mag, b_mag, spec_val;

    // Request decode: signedness, magnitudes and the short-circuit divide cases
    always_comb begin
        a_sgn    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
        b_sgn    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_sgn && rs1_data[XLEN-1];
        b_neg    = b_sgn && rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        special  = 1'b0;
        spec_val = '0;
        if (op[2] && (rs2_data == '0)) begin
            special  = 1'b1;
            spec_val = op[1] ? rs1_data : '1;
        end else if (((op == OP_DIV) || (op == OP_REM)) &&
                     (rs1_data == MIN_NEG) && (rs2_data == '1)) begin
            special  = 1'b1;
            spec_val = op[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration step of each algorithm
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   quo, rem, fin_val;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_next  = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        prod_fix  = neg_q ? -prod_q : prod_q;
        quo       = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem       = rem_neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        if (spec_q)
            fin_val = prod_q[XLEN-1:0];
        else if (op_q[2])
            fin_val = op_q[1] ? rem : quo;
        else
            fin_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and control strobes; flush overrides everything
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    load    = 1'b1;
                    state_d = special ? S_FINISH : S_CALC;
                end
                S_CALC: begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FINISH;
                end
                S_FINISH: begin
                    fin     = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            spec_q    <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= fin;
            if (load) begin
                op_q      <= op;
                rd_out    <= rd_in;
                cnt_q     <= '0;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                spec_q    <= special;
                opnd_q    <= op[2] ? b_mag : a_mag;
                if (special)    prod_q <= {{XLEN{1'b0}}, spec_val};
                else if (op[2]) prod_q <= {{XLEN{1'b0}}, a_mag};
                else            prod_q <= {{XLEN{1'b0}}, b_mag};
            end
            if (step) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                prod_q <= op_q[2] ? div_next : mul_next;
            end
            if (fin) result <= fin_val;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor checks each done.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int errors = 0;
    int checks = 0;
    logic [31:0] last_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact arithmetic on 64-bit extended operands
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa64, za64, sb64, zb64, p;
        longint sa, sb;
        sa64 = {{32{a[31]}}, a}; za64 = {32'b0, a};
        sb64 = {{32{b[31]}}, b}; zb64 = {32'b0, b};
        sa = longint'($signed(a)); sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa64 * sb64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * zb64; return p[63:32]; end
            3'd3: begin p = za64 * zb64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
        end
    endtask

    // Issue one request at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push);
        exp_t e;
        wait_idle();
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        if (push) begin
            e.res = ref_model(o, a, b);
            e.rd  = rd;
            e.cyc = cyc + 1 + latency(o, a, b);
            q.push_back(e);
            last_exp = e.res;
        end
        @(negedge clk);
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with result %h, expected no done", result);
            end else begin
                m_e = q.pop_front();
                chk("result", result, m_e.res);
                chk("rd_out", 32'(rd_out), 32'(m_e.rd));
                chk("done_cycle", 32'(cyc), 32'(m_e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_rd_out", 32'(rd_out), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7*6 with busy-length measurement
        issue(3'd0, 32'd7, 32'd6, 5'd5, 1'b1);
        nb = 1;
        while (busy && nb < 100) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("mul_busy_cycles", 32'(nb), 32'd33);

        // Directed cases, each issued in the previous done cycle
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
        issue(3'd5, 32'd100, 32'd7, 5'd8, 1'b1);
        issue(3'd7, 32'd100, 32'd7, 5'd9, 1'b1);
        issue(3'd5, 32'd5, 32'd0, 5'd10, 1'b1);
        issue(3'd6, 32'd5, 32'd0, 5'd11, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);

        // start while busy must be ignored
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b1);
        repeat (5) begin
            op = 3'd5; rs1_data = $urandom; rs2_data = 32'd0; rd_in = 5'd31; start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 40; i++)
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom), 1'b1);

        // flush at edge 10 cancels without done and keeps the old result
        issue(3'd4, 32'd1000, 32'd3, 5'd20, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_done", 32'(done), 32'h0);
        chk("flush_result", result, last_exp);
        repeat (40) @(negedge clk);
        chk("flush_result_hold", result, last_exp);

        // flush and start together: start dropped
        op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd21;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'h0);
        repeat (40) @(negedge clk);

        // async reset mid-operation clears everything before the next edge
        issue(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd9, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_result", result, 32'h0);
        chk("abort_rd_out", 32'(rd_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
